uart_rx_os16: RTL

- UART receiver for 8N1-style serial frames.
- Consumes the 16x-oversampling `baud_en` tick from the baud tick generator (one-cycle pulse, nominally 115200*16 Hz from a 100 MHz `clk`).
- Synchronizes `rx`, detects the start bit, samples each bit at mid-bit, checks the stop bit and presents the received byte with a one-cycle valid pulse.
- Sits between the board RX pin and downstream consumer logic (FIFO or command decoder).

---
 rtl/uart_rx_os16.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x-oversampled UART receiver (start + DATA_BITS + [parity] + stop).
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line idle, waiting for a low sample on a tick
// S_START | counting to mid start bit to confirm it is not a glitch
// S_DATA  | sampling data bits at mid-bit, LSB first
// S_PARITY| sampling the parity bit (parity build only)
// S_STOP  | sampling the stop bit, issuing the frame outcome
// S_BREAK | stop bit was low; wait for the line to return high
`timescale 1ns/1ps
module uart_rx_os16 #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TC_MID  = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] TC_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);
  localparam logic          P_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_sync1, r_sync2;
  logic [TW-1:0]        r_tcnt, w_tcnt_nxt;
  logic [BW-1:0]        r_bitcnt, w_bitcnt_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_par_err, w_par_err_nxt;
  logic [DATA_BITS-1:0] r_rx_data, w_rx_data_nxt;
  logic                 r_rx_valid, w_valid_nxt;
  logic                 r_frame_err, w_ferr_nxt;
  logic                 r_parity_err, w_perr_nxt;

  // Two-flop synchronizer on the asynchronous line; runs every clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state and datapath decode; nothing advances without a baud tick.
  always_comb begin
    w_state_nxt   = r_state;
    w_tcnt_nxt    = r_tcnt;
    w_bitcnt_nxt  = r_bitcnt;
    w_shift_nxt   = r_shift;
    w_par_err_nxt = r_par_err;
    w_rx_data_nxt = r_rx_data;
    w_valid_nxt   = 1'b0;
    w_ferr_nxt    = 1'b0;
    w_perr_nxt    = 1'b0;
    if (baud_en) begin
      w_tcnt_nxt = r_tcnt + TW'(1);
      case (r_state)
        S_IDLE: begin
          w_tcnt_nxt = '0;
          if (!r_sync2) begin
            w_state_nxt   = S_START;
            w_par_err_nxt = 1'b0;
          end
        end
        S_START: begin
          if (r_tcnt == TC_MID) begin
            w_tcnt_nxt = '0;
            if (!r_sync2) begin
              w_state_nxt  = S_DATA;
              w_bitcnt_nxt = '0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (r_tcnt == TC_END) begin
            w_tcnt_nxt   = '0;
            w_shift_nxt  = {r_sync2, r_shift[DATA_BITS-1:1]};
            w_bitcnt_nxt = r_bitcnt + BW'(1);
            if (r_bitcnt == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt = S_STOP;
`endif
            end
          end
        end
        S_PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (r_tcnt == TC_END) begin
            w_tcnt_nxt    = '0;
            // Mismatch when the received bit differs from XOR(data) ^ sense.
            w_par_err_nxt = r_sync2 ^ (^r_shift) ^ P_ODD;
            w_state_nxt   = S_STOP;
          end
`else
          w_tcnt_nxt  = '0;
          w_state_nxt = S_IDLE;
`endif
        end
        S_STOP: begin
          if (r_tcnt == TC_END) begin
            w_tcnt_nxt    = '0;
            w_rx_data_nxt = r_shift;
            w_perr_nxt    = r_par_err;
            if (r_sync2) begin
              w_valid_nxt = ~r_par_err;
              w_state_nxt = S_IDLE;
            end else begin
              w_ferr_nxt  = 1'b1;
              w_state_nxt = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          w_tcnt_nxt = '0;
          if (r_sync2) w_state_nxt = S_IDLE;
        end
        default: begin
          w_tcnt_nxt  = '0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State, counters, shift register and registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tcnt       <= '0;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tcnt       <= w_tcnt_nxt;
      r_bitcnt     <= w_bitcnt_nxt;
      r_shift      <= w_shift_nxt;
      r_par_err    <= w_par_err_nxt;
      r_rx_data    <= w_rx_data_nxt;
      r_rx_valid   <= w_valid_nxt;
      r_frame_err  <= w_ferr_nxt;
      r_parity_err <= w_perr_nxt;
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign busy       = (r_state != S_IDLE);

endmodule
